booth: RTL and testbench
========================

BOOTH -- requirements
Module: booth

Interface
REQ-001 The module SHALL have no parameters; operand width 8 and product width 16 are fixed constants from booth_pkg.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 x  input  8  multiplicand, two's-complement signed.
REQ-005 multiplier  input  8  multiplier, two's-complement signed.
REQ-006 final_result  output  16  signed product x*multiplier, registered.

Function
REQ-007 The module SHALL compute the full-precision signed product x*multiplier with no overflow or truncation, over the range -16256..16384.
REQ-008 Recoding SHALL be radix-8 Booth: multiplier sign-extended to 9 bits with an implicit 0 below bit 0, giving 3 overlapping 4-bit windows {m[2:0],0}, m[5:2] and m[8:5].
REQ-009 Each window SHALL map to a digit in {-4..+4}: d = -4*b3 + 2*b2 + b1 + b0.
REQ-010 The hard multiple 3x SHALL be formed once per operand as x + (x<<1), at 10-bit signed width.
REQ-011 Partial product i SHALL be the selected multiple (0, ±x, ±2x, ±3x, ±4x), sign-extended to 16 bits and shifted left by 3*i.
REQ-012 Negation SHALL be two's complement: invert plus a +1 correction summed with the same product.
REQ-013 final_result SHALL be the 16-bit sum of the 3 partial products.
REQ-014 With BOOTH_IN_REG_EN defined, the pipeline SHALL have 2 stages:
- stage 1 registers x, multiplier and 3x;
- stage 2 registers final_result.
REQ-015 With BOOTH_IN_REG_EN defined, latency SHALL be 2 rising edges.
REQ-016 The design SHALL accept a new operand pair on every clock (throughput 1/cycle), with no handshake.
REQ-017 Operands SHALL be sampled only at rising edges; input changes between edges SHALL have no effect on final_result until the next edge.
REQ-018 final_result SHALL hold its value between edges.

Reset
REQ-019 When RST=1 at a rising edge, all pipeline registers and final_result SHALL be cleared to 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight products.
REQ-021 After RST deasserts, the first valid result SHALL appear after the normal latency; until then final_result SHALL be 0.
REQ-022 RST SHALL take priority over new operand capture.

Configuration
REQ-023 Macro BOOTH_IN_REG_EN SHALL select the input-register stage, as follows.
- Defined: the input stage is present, with latency 2 cycles.
- Undefined: x and multiplier feed the recoder combinationally and only final_result is registered, with latency 1 cycle.
- Arithmetic results SHALL be identical in both builds.

Structure
REQ-024 Package booth_pkg SHALL hold the operand width (8) and product width (16) constants, and an enum typedef for the digit/multiple select (ZERO, P1, P2, P3, P4, N1..N4).
REQ-025 One sub-module, booth_r8_pp, SHALL take a 4-bit window and {x, 3x}, and produce one 16-bit signed partial product; booth SHALL instantiate it 3 times.

Verification
REQ-026 Reset and operand vectors (latency 2 with BOOTH_IN_REG_EN):
- RST=1 for 2 edges with any operands -> final_result=0x0000.
- x=0x89 (-119), multiplier=0x26 (38) -> 0xEE56 (-4522) after latency.
- x=0xB9 (-71), multiplier=0xE6 (-26) -> 0x0736 (1846).
- x=0x35 (53), multiplier=0x3E -> 0x0CD6.
REQ-027 Back-to-back vectors, one per clock:
- 0x7A*0x3F -> 0x1E06, then 0x05*0xFE -> 0xFFF6, then 0x3F*0x3F -> 0x0F81;
- results SHALL appear on consecutive cycles.
REQ-028 Extremes and reset mid-pipeline:
- 0x80*0x80 -> 0x4000.
- 0x80*0x7F -> 0xC080.
- 0x00*0x80 -> 0x0000.
- RST pulsed with a product in flight -> that product never appears, and final_result=0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared widths and radix-8 Booth digit encoding for the booth multiplier.
package booth_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int MUL_W  = 10;

    typedef enum logic [3:0] {
        ZERO, P1, P2, P3, P4, N1, N2, N3, N4
    } sel_t;

    // Window {b3,b2,b1,b0} maps to digit -4*b3 + 2*b2 + b1 + b0.
    function automatic sel_t booth_decode(input logic [3:0] win);
        sel_t s;
        case (win)
            4'b0001, 4'b0010: s = P1;
            4'b0011, 4'b0100: s = P2;
            4'b0101, 4'b0110: s = P3;
            4'b0111:          s = P4;
            4'b1000:          s = N4;
            4'b1001, 4'b1010: s = N3;
            4'b1011, 4'b1100: s = N2;
            4'b1101, 4'b1110: s = N1;
            default:          s = ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_r8_pp.sv
// One radix-8 Booth partial product: selects 0/±x/±2x/±3x/±4x, sign-extends, shifts.
// Purely combinational; no flow control.
module booth_r8_pp
    import booth_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic [3:0]        win,
    input  logic [OP_W-1:0]   x,
    input  logic [MUL_W-1:0]  x3,
    output logic [PROD_W-1:0] pp
);

    sel_t              sel;
    logic [MUL_W-1:0]  xe;
    logic [MUL_W-1:0]  mag;
    logic              neg;
    logic [PROD_W-1:0] mag_ext;
    logic [PROD_W-1:0] pp_raw;

    assign sel = booth_decode(win);
    assign xe  = {{(MUL_W-OP_W){x[OP_W-1]}}, x};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (sel)
            P1:      mag = xe;
            P2:      mag = xe << 1;
            P3:      mag = x3;
            P4:      mag = xe << 2;
            N1: begin mag = xe;      neg = 1'b1; end
            N2: begin mag = xe << 1; neg = 1'b1; end
            N3: begin mag = x3;      neg = 1'b1; end
            N4: begin mag = xe << 2; neg = 1'b1; end
            default: mag = '0;
        endcase
    end

    // Negation as invert plus the +1 correction folded into the same sum.
    assign mag_ext = {{(PROD_W-MUL_W){mag[MUL_W-1]}}, mag};
    assign pp_raw  = (mag_ext ^ {PROD_W{neg}}) + {{(PROD_W-1){1'b0}}, neg};
    assign pp      = pp_raw << SHIFT;

endmodule

// File: rtl/booth.sv
// 8x8 signed radix-8 Booth multiplier; latency 1 cycle, or 2 with BOOTH_IN_REG_EN defined.
// Accepts one operand pair per clock with no handshake.
module booth
    import booth_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   multiplier,
    output logic [PROD_W-1:0] final_result
);

    logic [MUL_W-1:0]  x_ext;
    logic [MUL_W-1:0]  x3_in;
    logic [OP_W-1:0]   x_s;
    logic [OP_W-1:0]   m_s;
    logic [MUL_W-1:0]  x3_s;
    logic [OP_W:0]     m9;
    logic [PROD_W-1:0] pp0, pp1, pp2;

    // The hard 3x multiple is built once per operand and shared by all digits.
    assign x_ext = {{(MUL_W-OP_W){x[OP_W-1]}}, x};
    assign x3_in = x_ext + (x_ext << 1);

`ifdef BOOTH_IN_REG_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_s  <= '0;
            m_s  <= '0;
            x3_s <= '0;
        end else begin
            x_s  <= x;
            m_s  <= multiplier;
            x3_s <= x3_in;
        end
    end
`else
    assign x_s  = x;
    assign m_s  = multiplier;
    assign x3_s = x3_in;
`endif

    assign m9 = {m_s[OP_W-1], m_s};

    booth_r8_pp #(.SHIFT(0)) u_pp0 (
        .win (m9[3:0] << 1),
        .x   (x_s),
        .x3  (x3_s),
        .pp  (pp0)
    );

    booth_r8_pp #(.SHIFT(3)) u_pp1 (
        .win (m9[5:2]),
        .x   (x_s),
        .x3  (x3_s),
        .pp  (pp1)
    );

    booth_r8_pp #(.SHIFT(6)) u_pp2 (
        .win (m9[8:5]),
        .x   (x_s),
        .x3  (x3_s),
        .pp  (pp2)
    );

    always_ff @(posedge CLK) begin
        if (RST) final_result <= '0;
        else     final_result <= pp0 + pp1 + pp2;
    end

endmodule

// File: tb/tb_booth.sv
// Directed-vector bench for booth; expected products are hand-computed constants.
module tb_booth;

`ifdef BOOTH_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        RST;
    logic [7:0]  x;
    logic [7:0]  multiplier;
    logic [15:0] final_result;

    int checks   = 0;
    int failures = 0;

    booth dut (
        .CLK          (CLK),
        .RST          (RST),
        .x            (x),
        .multiplier   (multiplier),
        .final_result (final_result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        x          = a;
        multiplier = b;
        repeat (LAT) @(posedge CLK);
        #1;
        check(tag, final_result, exp);
    endtask

    logic [7:0]  bb_a [3] = '{8'h7A, 8'h05, 8'h3F};
    logic [7:0]  bb_b [3] = '{8'h3F, 8'hFE, 8'h3F};
    logic [15:0] bb_p [3] = '{16'h1E06, 16'hFFF6, 16'h0F81};

    initial begin
        RST        = 1'b1;
        x          = 8'h89;
        multiplier = 8'h26;
        @(posedge CLK); #1;
        check("reset_edge1", final_result, 16'h0000);
        @(posedge CLK); #1;
        check("reset_edge2", final_result, 16'h0000);
        RST = 1'b0;

        run_vec("neg_x_pos_m", 8'h89, 8'h26, 16'hEE56);
        run_vec("neg_x_neg_m", 8'hB9, 8'hE6, 16'h0736);
        run_vec("pos_x_pos_m", 8'h35, 8'h3E, 16'h0CD6);

        // Inputs wiggle between edges; the registered output must not move.
        x          = 8'h7F;
        multiplier = 8'h7F;
        #3;
        check("hold_between_edges", final_result, 16'h0CD6);
        x          = 8'h35;
        multiplier = 8'h3E;
        @(posedge CLK); #1;

        // Back-to-back issue: one pair per clock, results on consecutive cycles.
        for (int c = 0; c < 3 + LAT - 1; c++) begin
            if (c < 3) begin
                x          = bb_a[c];
                multiplier = bb_b[c];
            end
            @(posedge CLK); #1;
            if (c >= LAT - 1) begin
                case (c - LAT + 1)
                    0: check("b2b_0", final_result, bb_p[0]);
                    1: check("b2b_1", final_result, bb_p[1]);
                    default: check("b2b_2", final_result, bb_p[2]);
                endcase
            end
        end

        run_vec("min_times_min", 8'h80, 8'h80, 16'h4000);
        run_vec("min_times_max", 8'h80, 8'h7F, 16'hC080);
        run_vec("zero_times_min", 8'h00, 8'h80, 16'h0000);
        run_vec("max_times_max", 8'h7F, 8'h7F, 16'h3F01);

        // Product in flight when reset hits must never surface.
        x          = 8'h7A;
        multiplier = 8'h3F;
        repeat (LAT - 1) @(posedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("reset_mid_flush", final_result, 16'h0000);
        RST        = 1'b0;
        x          = 8'h05;
        multiplier = 8'hFE;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge CLK); #1;
            if (k < LAT) check("post_reset_zero", final_result, 16'h0000);
            else         check("post_reset_first", final_result, 16'hFFF6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
